route_compute_unit: RTL and testbench

ROUTE_COMPUTE_UNIT -- requirements
Module: route_compute_unit

---
 rtl/route_compute_unit.sv | 148 ++++++++++++++
 tb/tb_route_compute_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/route_compute_unit.sv
// Route computation for a 2-D mesh router.
// Each input port holds an output-port decision for the whole packet.
// The decision is taken on the head flit and released on the fired tail flit.
// Routing is XY or YX dimension-order. Output codes are 0=LOCAL 1=WEST 2=NORTH 3=EAST 4=SOUTH.
module route_compute_unit #(
  parameter int NOC_WIDTH    = 4,
  parameter int NOC_LENGTH   = 4,
  parameter int ROUTER_ID    = 0,
  parameter int NUM_PORTS    = 5,
  parameter int ROUTING_MODE = 0,
  localparam int XW          = $clog2(NOC_WIDTH),
  localparam int YW          = $clog2(NOC_LENGTH),
  localparam int AW          = XW + YW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_PORTS-1:0]    flit_valid,
  input  logic [NUM_PORTS-1:0]    flit_head,
  input  logic [NUM_PORTS-1:0]    flit_tail,
  input  logic [NUM_PORTS*AW-1:0] flit_dest,
  input  logic [NUM_PORTS-1:0]    flit_fire,
  output logic [NUM_PORTS-1:0]    route_valid,
  output logic [NUM_PORTS*3-1:0]  route_port,
  output logic [NUM_PORTS-1:0]    route_err
);

  localparam logic [2:0] P_LOCAL = 3'd0;
  localparam logic [2:0] P_WEST  = 3'd1;
  localparam logic [2:0] P_NORTH = 3'd2;
  localparam logic [2:0] P_EAST  = 3'd3;
  localparam logic [2:0] P_SOUTH = 3'd4;

  // This router's coordinates. Y grows toward SOUTH.
  localparam logic [XW-1:0] MY_X  = XW'(ROUTER_ID % NOC_WIDTH);
  localparam logic [YW-1:0] MY_Y  = YW'(ROUTER_ID / NOC_WIDTH);
  // Mesh extents. They are one bit wider so a full power-of-two extent still fits.
  localparam logic [XW:0]   X_LIM = (XW+1)'(NOC_WIDTH);
  localparam logic [YW:0]   Y_LIM = (YW+1)'(NOC_LENGTH);

  typedef enum logic {IDLE, ROUTED} state_e;

  state_e     state_q [NUM_PORTS];
  state_e     state_d [NUM_PORTS];
  logic [2:0] port_q  [NUM_PORTS];
  logic [2:0] port_d  [NUM_PORTS];
  logic       err_q   [NUM_PORTS];
  logic       err_d   [NUM_PORTS];

  // A destination is outside the mesh when either coordinate is past its extent.
  function automatic logic addr_bad(input logic [AW-1:0] dest);
    logic [XW-1:0] dx;
    logic [YW-1:0] dy;
    dx = dest[XW-1:0];
    dy = dest[AW-1:XW];
    return ({1'b0, dx} >= X_LIM) || ({1'b0, dy} >= Y_LIM);
  endfunction

  // Dimension-order routing with plain unsigned compares. The mesh has no wraparound.
  function automatic logic [2:0] calc_route(input logic [AW-1:0] dest);
    logic [XW-1:0] dx;
    logic [YW-1:0] dy;
    logic [2:0]    xdir;
    logic [2:0]    ydir;
    logic [2:0]    r;
    dx   = dest[XW-1:0];
    dy   = dest[AW-1:XW];
    xdir = (dx > MY_X) ? P_EAST : P_WEST;
    ydir = (dy > MY_Y) ? P_SOUTH : P_NORTH;
    r    = P_LOCAL;
    if (ROUTING_MODE == 0) begin
      if (dx != MY_X)      r = xdir;
      else if (dy != MY_Y) r = ydir;
    end else begin
      if (dy != MY_Y)      r = ydir;
      else if (dx != MY_X) r = xdir;
    end
    return r;
  endfunction

  // Per-port next state: take the route on a head, release it on a fired tail.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      logic [AW-1:0] dest_p;
      logic          head_ev;
      logic          tail_fire;
      // NOTE: every target gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
      state_d[p] = state_q[p];
      port_d[p]  = port_q[p];
      err_d[p]   = err_q[p];
      dest_p     = flit_dest[p*AW +: AW];
      head_ev    = flit_valid[p] & flit_head[p];
      tail_fire  = flit_valid[p] & flit_tail[p] & flit_fire[p];
      case (state_q[p])
        IDLE: begin
          // A tail or fire seen in IDLE is ignored. This includes the fire of a
          // single-flit packet in the cycle its head arrives.
          if (head_ev) begin
            state_d[p] = ROUTED;
            if (addr_bad(dest_p)) begin
              err_d[p]  = 1'b1;
              port_d[p] = P_LOCAL;
            end else begin
              port_d[p] = calc_route(dest_p);
            end
          end
        end
        ROUTED: begin
          // A second head is a protocol error. The held route is kept.
          if (head_ev)        err_d[p]   = 1'b1;
          else if (tail_fire) state_d[p] = IDLE;
        end
        default: state_d[p] = IDLE;
      endcase
    end
  end

  // State registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the per-port arrays are ordinary flops, not a RAM, so every entry is reset explicitly.
      for (int p = 0; p < NUM_PORTS; p++) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
        state_q[p] <= IDLE;
        port_q[p]  <= P_LOCAL;
        err_q[p]   <= 1'b0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        state_q[p] <= state_d[p];
        port_q[p]  <= port_d[p];
        err_q[p]   <= err_d[p];
      end
    end
  end

  // Output flattening. The port code is forced to 0 whenever no route is held.
  always_comb begin
    route_valid = '0;
    route_port  = '0;
    route_err   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      route_valid[p] = (state_q[p] == ROUTED);
      if (state_q[p] == ROUTED) route_port[p*3 +: 3] = port_q[p];
      route_err[p]   = err_q[p];
    end
  end

endmodule

// File: tb/tb_route_compute_unit.sv
// Directed bench for route_compute_unit. It uses three instances.
// The 4x4 XY and 4x4 YX instances both sit at router 5, which is (x=1, y=1).
// The 3x4 XY instance sits at router 4, also (x=1, y=1). It is used for out-of-mesh checks.
module tb_route_compute_unit;

  localparam int NP = 5;
  localparam int AW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NP-1:0]   valid, head, tail, fire;
  logic [NP*AW-1:0] dest;

  logic [NP-1:0]   rv_xy, er_xy, rv_yx, er_yx, rv_w3, er_w3;
  logic [NP*3-1:0] rp_xy, rp_yx, rp_w3;

  always #5 clk = ~clk;

  route_compute_unit #(.NOC_WIDTH(4), .NOC_LENGTH(4), .ROUTER_ID(5), .NUM_PORTS(NP), .ROUTING_MODE(0)) u_xy (
    .clk(clk), .rst_n(rst_n), .flit_valid(valid), .flit_head(head), .flit_tail(tail),
    .flit_dest(dest), .flit_fire(fire), .route_valid(rv_xy), .route_port(rp_xy), .route_err(er_xy));

  route_compute_unit #(.NOC_WIDTH(4), .NOC_LENGTH(4), .ROUTER_ID(5), .NUM_PORTS(NP), .ROUTING_MODE(1)) u_yx (
    .clk(clk), .rst_n(rst_n), .flit_valid(valid), .flit_head(head), .flit_tail(tail),
    .flit_dest(dest), .flit_fire(fire), .route_valid(rv_yx), .route_port(rp_yx), .route_err(er_yx));

  route_compute_unit #(.NOC_WIDTH(3), .NOC_LENGTH(4), .ROUTER_ID(4), .NUM_PORTS(NP), .ROUTING_MODE(0)) u_w3 (
    .clk(clk), .rst_n(rst_n), .flit_valid(valid), .flit_head(head), .flit_tail(tail),
    .flit_dest(dest), .flit_fire(fire), .route_valid(rv_w3), .route_port(rp_w3), .route_err(er_w3));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid = '0; head = '0; tail = '0; fire = '0; dest = '0;
  endtask

  // Port-0 vector. Inputs are applied for one cycle. The outputs expected after that edge follow.
  typedef struct packed {
    logic       v, h, t, f;
    logic [3:0] d;
    logic       exp_valid;
    logic [2:0] exp_xy;
    logic [2:0] exp_yx;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  initial begin
    // Dest encoding is {y[1:0], x[1:0]}. The router is at x=1, y=1.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'hE, 1'b1, 3'd3, 3'd4}; // head (y3,x2), fire ignored
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'h5, 1'b1, 3'd3, 3'd4}; // body with new dest: ignored
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 3'd3, 3'd4}; // body
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 3'd3, 3'd4}; // body, not fired
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 3'd3, 3'd4}; // tail, not fired: still held
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 3'd0, 3'd0}; // tail fired: release
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 3'd0, 3'd0}; // stray fire in IDLE
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 3'd0, 3'd0}; // stray tail fire in IDLE
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h5, 1'b1, 3'd0, 3'd0}; // single flit to self: LOCAL
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 3'd0, 3'd0}; // its fire cycle: release
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h1, 1'b1, 3'd2, 3'd2}; // (y0,x1): NORTH both
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 3'd0, 3'd0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h3, 1'b1, 3'd3, 3'd2}; // (y0,x3): XY EAST, YX NORTH
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 3'd0, 3'd0};

    // Reset with heads active on every port: everything must stay at zero.
    rst_n = 1'b0;
    idle_inputs();
    valid = '1; head = '1; dest = 20'hE1D47;
    tick();
    tick();
    check("reset rv_xy", 32'(rv_xy), 32'h0);
    check("reset rp_xy", 32'(rp_xy), 32'h0);
    check("reset er_xy", 32'(er_xy), 32'h0);
    check("reset rv_w3", 32'(rv_w3), 32'h0);
    idle_inputs();
    rst_n = 1'b1;
    tick();

    // Table-driven port-0 sequence.
    for (int i = 0; i < NV; i++) begin
      idle_inputs();
      valid[0] = tbl[i].v; head[0] = tbl[i].h; tail[0] = tbl[i].t; fire[0] = tbl[i].f;
      dest[3:0] = tbl[i].d;
      tick();
      check($sformatf("row%0d xy valid", i), 32'(rv_xy), 32'(tbl[i].exp_valid));
      check($sformatf("row%0d xy port", i),  32'(rp_xy), 32'(tbl[i].exp_xy));
      check($sformatf("row%0d yx valid", i), 32'(rv_yx), 32'(tbl[i].exp_valid));
      check($sformatf("row%0d yx port", i),  32'(rp_yx), 32'(tbl[i].exp_yx));
      check($sformatf("row%0d xy err", i),   32'(er_xy), 32'h0);
      check($sformatf("row%0d yx err", i),   32'(er_yx), 32'h0);
    end

    // All five ports receive heads at once. Dests in (y,x) order are (0,1),(1,0),(1,3),(3,1),(1,1).
    idle_inputs();
    valid = '1; head = '1;
    dest = {4'h5, 4'hD, 4'h7, 4'h4, 4'h1};
    tick();
    check("multi rv_xy", 32'(rv_xy), 32'h1F);
    check("multi rp_xy", 32'(rp_xy), 32'({3'd0, 3'd4, 3'd3, 3'd1, 3'd2}));
    check("multi rp_yx", 32'(rp_yx), 32'({3'd0, 3'd4, 3'd3, 3'd1, 3'd2}));
    check("multi er_xy", 32'(er_xy), 32'h0);

    // A second head on port 2 while it is routed: error flag, route kept.
    idle_inputs();
    valid[2] = 1'b1; head[2] = 1'b1; dest[11:8] = 4'h4;
    tick();
    check("rehead er_xy", 32'(er_xy), 32'h04);
    check("rehead rp_xy", 32'(rp_xy), 32'({3'd0, 3'd4, 3'd3, 3'd1, 3'd2}));
    check("rehead rv_xy", 32'(rv_xy), 32'h1F);

    // Release all ports. The error flag is sticky.
    idle_inputs();
    valid = '1; tail = '1; fire = '1;
    tick();
    check("release rv_xy", 32'(rv_xy), 32'h0);
    check("release rp_xy", 32'(rp_xy), 32'h0);
    check("sticky er_xy",  32'(er_xy), 32'h04);

    // Reset mid-packet, asserted together with a fired tail.
    idle_inputs();
    valid[0] = 1'b1; head[0] = 1'b1; dest[3:0] = 4'hE;
    tick();
    check("pre-reset rv_xy", 32'(rv_xy), 32'h01);
    idle_inputs();
    valid[0] = 1'b1; tail[0] = 1'b1; fire[0] = 1'b1;
    rst_n = 1'b0;
    tick();
    check("midreset rv_xy", 32'(rv_xy), 32'h0);
    check("midreset rp_xy", 32'(rp_xy), 32'h0);
    check("midreset er_xy", 32'(er_xy), 32'h0);
    check("midreset er_w3", 32'(er_w3), 32'h0);
    check("midreset rv_yx", 32'(rv_yx), 32'h0);

    // The first head after reset is accepted in the same cycle reset deasserts.
    idle_inputs();
    rst_n = 1'b1;
    valid[0] = 1'b1; head[0] = 1'b1; dest[3:0] = 4'hE;
    tick();
    check("post-reset rv_xy", 32'(rv_xy), 32'h01);
    check("post-reset rp_xy", 32'(rp_xy), 32'd3);
    check("post-reset rp_yx", 32'(rp_yx), 32'd4);
    check("post-reset rp_w3", 32'(rp_w3), 32'd3);
    check("post-reset er_w3", 32'(er_w3), 32'h0);
    idle_inputs();
    valid[0] = 1'b1; tail[0] = 1'b1; fire[0] = 1'b1;
    tick();
    check("post-reset release", 32'(rv_xy), 32'h0);

    // On the 3-wide mesh, x=3 is outside the mesh. It sets the error flag and routes LOCAL.
    idle_inputs();
    valid[1] = 1'b1; head[1] = 1'b1; dest[7:4] = 4'h7;
    tick();
    check("oob er_w3", 32'(er_w3), 32'h02);
    check("oob rv_w3", 32'(rv_w3), 32'h02);
    check("oob rp_w3", 32'(rp_w3), 32'h0);
    check("oob er_xy", 32'(er_xy), 32'h0);
    check("oob rp_xy", 32'(rp_xy), 32'(3'd3) << 3);
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
